sram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port `simple_sram` (synchronous write, one-cycle registered read).

- Accepts independent valid/ready memory requests from two masters.
- Serialises them onto the SRAM's `we`/`oe`/`address`/`data_in` pins.
- Returns a one-cycle response pulse carrying read data, or acting as a write acknowledge, to the granted master.
- Sits directly in front of the SRAM; nothing else drives the SRAM pins.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/sram_arbiter.sv | 113 +++++++++++
 tb/tb_sram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter
package sram_arb_pkg;

  // Sequencer phases: idle, SRAM strobe, response
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant logic
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Lone requester wins outright; on contention the master not served last wins
  always_comb begin
    grant     = 2'b00;
    grant_idx = M0;
    case (req)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = M0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = M1;
      end
      2'b11: begin
        if (last == M0) begin
          grant     = 2'b10;
          grant_idx = M1;
        end else begin
          grant     = 2'b01;
          grant_idx = M0;
        end
      end
      default: begin
        grant     = 2'b00;
        grant_idx = M0;
      end
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master round-robin sequencer in front of a single-port SRAM
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_valid,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic                  m0_rsp_valid,
  input  logic                  m1_valid,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic                  r_we;
  logic                  r_gidx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [1:0]            w_grant;
  logic                  w_grant_idx;
  logic                  w_accept;
  logic                  w_hs;

  rr_arbiter2 u_rr (
    .req       ({m1_valid, m0_valid}),
    .last      (r_last),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  // rst_n gates the window so ready is low for the whole reset, even with valid held high
  assign w_accept = rst_n && (r_state != ST_ACCESS);
  assign w_hs     = w_accept && (w_grant != 2'b00);
  assign m0_ready = w_accept && w_grant[0];
  assign m1_ready = w_accept && w_grant[1];

  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign rsp_rdata  = sram_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus strobes and response pulses decoded from the current phase
  always_comb begin
    w_state_nxt  = r_state;
    sram_we      = 1'b0;
    sram_oe      = 1'b0;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = w_hs ? ST_ACCESS : ST_IDLE;
      end
      ST_ACCESS: begin
        w_state_nxt = ST_DONE;
        sram_we     = r_we;
        sram_oe     = !r_we;
      end
      ST_DONE: begin
        w_state_nxt  = w_hs ? ST_ACCESS : ST_IDLE;
        m0_rsp_valid = (r_gidx == M0);
        m1_rsp_valid = (r_gidx == M1);
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the accepted request and move the round-robin pointer to its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= M1;
      r_we    <= 1'b0;
      r_gidx  <= M0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_hs) begin
      r_last  <= w_grant_idx;
      r_gidx  <= w_grant_idx;
      r_we    <= (w_grant_idx == M1) ? m1_we    : m0_we;
      r_addr  <= (w_grant_idx == M1) ? m1_addr  : m0_addr;
      r_wdata <= (w_grant_idx == M1) ? m1_wdata : m0_wdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       m0_valid, m0_we, m0_ready, m0_rsp_valid;
  logic [3:0] m0_addr;
  logic [7:0] m0_wdata;
  logic       m1_valid, m1_we, m1_ready, m1_rsp_valid;
  logic [3:0] m1_addr;
  logic [7:0] m1_wdata;
  logic [7:0] rsp_rdata;
  logic       sram_we, sram_oe;
  logic [3:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata;

  int n_run  = 0;
  int n_fail = 0;

  sram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_valid     (m0_valid),
    .m0_we        (m0_we),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_ready     (m0_ready),
    .m0_rsp_valid (m0_rsp_valid),
    .m1_valid     (m1_valid),
    .m1_we        (m1_we),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_ready     (m1_ready),
    .m1_rsp_valid (m1_rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .sram_we      (sram_we),
    .sram_oe      (sram_oe),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // simple_sram: synchronous write, registered read
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_oe) sram_rdata <= mem[sram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles since the last accepted request, and who owns it
  function automatic int grant_of(input logic v0, input logic v1, input logic lst);
    if (v0 && v1) return (lst == 1'b1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  int         md_age;
  logic       md_last;
  logic       md_g;
  logic       md_we;
  logic [3:0] md_addr;
  logic [7:0] md_wdata;
  logic [7:0] md_rdata;
  logic [7:0] ref_mem [16];
  int         md_gnt;

  always_comb md_gnt = grant_of(m0_valid, m1_valid, md_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_age   <= 3;
      md_last  <= 1'b1;
      md_addr  <= '0;
      md_wdata <= '0;
    end else if (md_age != 1 && md_gnt >= 0) begin
      md_age  <= 1;
      md_g    <= md_gnt[0];
      md_last <= md_gnt[0];
      if (md_gnt == 0) begin
        md_we    <= m0_we;
        md_addr  <= m0_addr;
        md_wdata <= m0_wdata;
        md_rdata <= ref_mem[m0_addr];
        if (m0_we) ref_mem[m0_addr] <= m0_wdata;
      end else begin
        md_we    <= m1_we;
        md_addr  <= m1_addr;
        md_wdata <= m1_wdata;
        md_rdata <= ref_mem[m1_addr];
        if (m1_we) ref_mem[m1_addr] <= m1_wdata;
      end
    end else if (md_age < 3) begin
      md_age <= md_age + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("we_oe_exclusive", {31'b0, sram_we & sram_oe}, 32'd0);
    if (!rst_n) begin
      check("rst_m0_ready", m0_ready, 0);
      check("rst_m1_ready", m1_ready, 0);
      check("rst_m0_rsp", m0_rsp_valid, 0);
      check("rst_m1_rsp", m1_rsp_valid, 0);
      check("rst_sram_we", sram_we, 0);
      check("rst_sram_oe", sram_oe, 0);
      check("rst_sram_addr", sram_addr, 0);
      check("rst_sram_wdata", sram_wdata, 0);
    end else begin
      check("m0_ready", m0_ready, (md_age != 1) && (md_gnt == 0));
      check("m1_ready", m1_ready, (md_age != 1) && (md_gnt == 1));
      check("sram_we", sram_we, (md_age == 1) && md_we);
      check("sram_oe", sram_oe, (md_age == 1) && !md_we);
      check("sram_addr", sram_addr, md_addr);
      check("sram_wdata", sram_wdata, md_wdata);
      check("m0_rsp_valid", m0_rsp_valid, (md_age == 2) && (md_g == 1'b0));
      check("m1_rsp_valid", m1_rsp_valid, (md_age == 2) && (md_g == 1'b1));
      if (md_age == 2 && !md_we) check("rsp_rdata", rsp_rdata, md_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Issue one request, wait for handshake and response; rd returns the response data
  task automatic do_req(input int m, input logic we, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] rd);
    logic hs;
    logic got;
    hs  = 1'b0;
    got = 1'b0;
    rd  = '0;
    drive(m, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = (m == 0) ? m0_ready : m1_ready;
      step();
    end
    drive(m, 1'b0, we, a, d);
    check("handshake_in_time", hs, 1);
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_rsp_valid : m1_rsp_valid) begin
        got = 1'b1;
        rd  = rsp_rdata;
      end
      step();
    end
    check("response_in_time", got, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int hs_cnt;
    int order [8];
    int cyc_at [8];
    int rsp_seen;
    int m0_rsp_cnt;

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    step();
    step();
    @(negedge clk);
    check("reset_sram_we", sram_we, 0);
    check("reset_m0_ready", m0_ready, 0);
    step();
    rst_n = 1'b1;

    // m0 writes 0xA5 to address 3
    drive(0, 1'b1, 1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    check("wr_c0_m0_ready", m0_ready, 1);
    step();
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    @(negedge clk);
    check("wr_c1_sram_we", sram_we, 1);
    check("wr_c1_sram_addr", sram_addr, 3);
    check("wr_c1_sram_wdata", sram_wdata, 8'hA5);
    step();
    @(negedge clk);
    check("wr_c2_m0_rsp", m0_rsp_valid, 1);
    step();

    // m1 reads address 3
    drive(1, 1'b1, 1'b0, 4'd3, 8'd0);
    @(negedge clk);
    check("rd_c0_m1_ready", m1_ready, 1);
    step();
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    @(negedge clk);
    check("rd_c1_sram_oe", sram_oe, 1);
    check("rd_c1_sram_we", sram_we, 0);
    step();
    @(negedge clk);
    check("rd_c2_m1_rsp", m1_rsp_valid, 1);
    check("rd_c2_m0_rsp", m0_rsp_valid, 0);
    check("rd_c2_rdata", rsp_rdata, 8'hA5);
    step();

    // Seed addresses 1 and 2; m1 goes last so m0 wins the next contention
    do_req(0, 1'b1, 4'd1, 8'h11, rd);
    do_req(1, 1'b1, 4'd2, 8'h22, rd);

    // Continuous contention: both masters read, 8 handshakes
    hs_cnt = 0;
    drive(0, 1'b1, 1'b0, 4'd1, 8'd0);
    drive(1, 1'b1, 1'b0, 4'd2, 8'd0);
    for (int i = 0; i < 40 && hs_cnt < 8; i++) begin
      @(negedge clk);
      if (m0_ready) begin
        order[hs_cnt] = 0; cyc_at[hs_cnt] = i; hs_cnt++;
      end else if (m1_ready) begin
        order[hs_cnt] = 1; cyc_at[hs_cnt] = i; hs_cnt++;
      end
      step();
    end
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    check("contention_count", hs_cnt, 8);
    for (int k = 0; k < hs_cnt; k++) begin
      check("contention_order", order[k], k % 2);
      if (k > 0) check("contention_spacing", cyc_at[k] - cyc_at[k-1], 2);
    end
    step();
    step();

    // Boundary address/data and read-after-write across masters
    do_req(0, 1'b1, 4'd15, 8'hFF, rd);
    do_req(1, 1'b0, 4'd15, 8'h00, rd);
    check("raw_addr15", rd, 8'hFF);
    do_req(1, 1'b1, 4'd0, 8'h3C, rd);
    do_req(0, 1'b0, 4'd0, 8'h00, rd);
    check("raw_addr0", rd, 8'h3C);
    check("addr0_no_x", {31'b0, $isunknown(rd)}, 0);

    // Reset asserted during a read's ACCESS cycle
    drive(0, 1'b1, 1'b0, 4'd1, 8'd0);
    @(negedge clk);
    check("rstmid_hs", m0_ready, 1);
    step();
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    rst_n = 1'b0;
    #1;
    check("rstmid_sram_oe", sram_oe, 0);
    check("rstmid_sram_addr", sram_addr, 0);
    check("rstmid_rsp", {31'b0, m0_rsp_valid | m1_rsp_valid}, 0);
    step();
    step();
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m0_rsp_valid || m1_rsp_valid) rsp_seen++;
      step();
    end
    check("rstmid_no_rsp_after", rsp_seen, 0);
    drive(0, 1'b1, 1'b0, 4'd1, 8'd0);
    drive(1, 1'b1, 1'b0, 4'd2, 8'd0);
    @(negedge clk);
    check("post_rst_m0_wins", m0_ready, 1);
    check("post_rst_m1_waits", m1_ready, 0);
    step();
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    step();
    step();
    step();

    // m1 pulses valid for one cycle during m0's ACCESS
    drive(0, 1'b1, 1'b0, 4'd2, 8'd0);
    @(negedge clk);
    check("pulse_m0_hs", m0_ready, 1);
    step();
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b1, 1'b0, 4'd5, 8'd0);
    @(negedge clk);
    check("pulse_m1_ready", m1_ready, 0);
    step();
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    rsp_seen   = 0;
    m0_rsp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m1_rsp_valid) rsp_seen++;
      if (m0_rsp_valid) m0_rsp_cnt++;
      if (i > 0 && (sram_oe || sram_we)) rsp_seen++;
      step();
    end
    check("pulse_m1_no_activity", rsp_seen, 0);
    check("pulse_m0_one_rsp", m0_rsp_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
